video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the VGA/HDMI video path. It replaces the fixed 640x480 timing and game-update-tick logic currently spread across the draw and update-clock blocks.
- Outputs undelayed pixel coordinates to the entity/draw logic.
- Outputs hsync/vsync/de delayed by a configurable pipeline depth, so they line up with RGB produced PIPE_DELAY cycles later.
- Emits a game update tick once every TICK_DIV frames, at the start of vertical blanking.

---
 rtl/video_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: undelayed pixel coordinates, pipelined sync/de,
// and a frame-divided game update tick at the start of vertical blanking.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 2,
  parameter int TICK_DIV   = 1,
  parameter int COORD_W    = 10
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               pause_tick,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               active_raw,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_de,
  output logic               line_start,
  output logic               frame_start,
  output logic               update_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam longint CNT_RANGE = longint'(1) << COORD_W;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      TICK_DIV < 1 || TICK_DIV > 255 ||
      PIPE_DELAY < 0 || PIPE_DELAY > 15 ||
      COORD_W < 1 || COORD_W > 30 ||
      longint'(H_TOTAL) > CNT_RANGE ||
      longint'(V_TOTAL) > CNT_RANGE) begin : g_param_check
    $fatal(1, "video_timing_gen: illegal parameter set");
  end

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]         DIV_LAST = 8'(TICK_DIV - 1);

  // Bundle layout: {de, hsync, vsync}
  localparam logic [2:0] RAW_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [7:0]         div_q, div_d;
  logic [2:0]         raw_q, raw_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic               tick_q, tick_d;
  logic               h_wrap;
  logic               hs_on;
  logic               vs_on;
  logic               tick_pt;
  logic [2:0]         dly;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    hs_on = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_on = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    raw_d = {(h_cnt_q < H_ACT) && (v_cnt_q < V_ACT),
             hs_on ? HSYNC_POL : ~HSYNC_POL,
             vs_on ? VSYNC_POL : ~VSYNC_POL};

    x_d  = h_cnt_q;
    y_d  = v_cnt_q;
    ls_d = (h_cnt_q == '0);
    fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Divider only moves at the first blanking line, never while paused.
    tick_pt = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
    div_d   = div_q;
    tick_d  = 1'b0;
    if (tick_pt && !pause_tick) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      div_q   <= '0;
      raw_q   <= RAW_RST;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      div_q   <= div_d;
      raw_q   <= raw_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      tick_q  <= tick_d;
    end
  end

  if (PIPE_DELAY > 0) begin : g_pipe
    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    always_comb begin
      pipe_d[0] = raw_q;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= RAW_RST;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign dly = pipe_q[PIPE_DELAY-1];
  end else begin : g_nopipe
    assign dly = raw_q;
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign active_raw  = raw_q[2];
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign update_tick = tick_q;
  assign vga_de      = dly[2];
  assign vga_hsync   = dly[1];
  assign vga_vsync   = dly[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 timing plus small-geometry instances
// that make full frames, tick division and pause affordable to simulate.
module tb_video_timing_gen;

  logic clk;
  logic rst_d, rst_s, rst_p, rst_z;
  logic pause_d, pause_s, pause_p, pause_z;

  logic [9:0] d_x, d_y;
  logic d_act, d_hs, d_vs, d_de, d_ls, d_fs, d_tick;
  logic [4:0] s_x, s_y;
  logic s_act, s_hs, s_vs, s_de, s_ls, s_fs, s_tick;
  logic [4:0] p_x, p_y;
  logic p_act, p_hs, p_vs, p_de, p_ls, p_fs, p_tick;
  logic [4:0] z_x, z_y;
  logic z_act, z_hs, z_vs, z_de, z_ls, z_fs, z_tick;

  int checks = 0;
  int errors = 0;

  // Small geometry: 16 clocks per line, 10 lines per frame
  localparam int SH = 16;
  localparam int SV = 10;
  localparam int SF = SH * SV;

  video_timing_gen u_def (
    .vga_clk(clk), .reset(rst_d), .pause_tick(pause_d),
    .x_out(d_x), .y_out(d_y), .active_raw(d_act),
    .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_de(d_de),
    .line_start(d_ls), .frame_start(d_fs), .update_tick(d_tick)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(2), .TICK_DIV(3), .COORD_W(5)
  ) u_s3 (
    .vga_clk(clk), .reset(rst_s), .pause_tick(pause_s),
    .x_out(s_x), .y_out(s_y), .active_raw(s_act),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_de(s_de),
    .line_start(s_ls), .frame_start(s_fs), .update_tick(s_tick)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(2), .TICK_DIV(2), .COORD_W(5)
  ) u_p2 (
    .vga_clk(clk), .reset(rst_p), .pause_tick(pause_p),
    .x_out(p_x), .y_out(p_y), .active_raw(p_act),
    .vga_hsync(p_hs), .vga_vsync(p_vs), .vga_de(p_de),
    .line_start(p_ls), .frame_start(p_fs), .update_tick(p_tick)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .PIPE_DELAY(0), .TICK_DIV(1), .COORD_W(5)
  ) u_z0 (
    .vga_clk(clk), .reset(rst_z), .pause_tick(pause_z),
    .x_out(z_x), .y_out(z_y), .active_raw(z_act),
    .vga_hsync(z_hs), .vga_vsync(z_vs), .vga_de(z_de),
    .line_start(z_ls), .frame_start(z_fs), .update_tick(z_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1;
    repeat (3) step();
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0) begin
      errors++;
      $display("FAIL rst_xy got %0d,%0d want 0,0", d_x, d_y);
    end
    checks++;
    if ({d_act, d_ls, d_fs, d_tick, d_de} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 00000",
               {d_act, d_ls, d_fs, d_tick, d_de});
    end
    checks++;
    if ({d_hs, d_vs} !== 2'b11) begin
      errors++;
      $display("FAIL rst_sync got %b want 11", {d_hs, d_vs});
    end
    rst_d = 1'b0;
    step();
    checks++;
    if ({d_x, d_y} !== 20'd0 || {d_act, d_ls, d_fs, d_de} !== 4'b1110) begin
      errors++;
      $display("FAIL cycle0 got x%0d y%0d act/ls/fs/de %b want 0 0 1110",
               d_x, d_y, {d_act, d_ls, d_fs, d_de});
    end
    step();
    checks++;
    if (d_x !== 10'd1 || d_de !== 1'b0 || d_fs !== 1'b0) begin
      errors++;
      $display("FAIL cycle1 got x%0d de%b fs%b want x1 de0 fs0",
               d_x, d_de, d_fs);
    end
    step();
    checks++;
    if (d_x !== 10'd2 || d_de !== 1'b1) begin
      errors++;
      $display("FAIL cycle2 got x%0d de%b want x2 de1", d_x, d_de);
    end
  endtask

  task automatic test_default_lines();
    int mm = 0;
    int first = -1;
    int de_cnt = 0;
    int hs_cnt = 0;
    for (int n = 3; n <= 2401; n++) begin
      int h, v, hp, vp;
      logic e_hs, e_de;
      step();
      h  = n % 800;
      v  = n / 800;
      hp = (n - 2) % 800;
      vp = (n - 2) / 800;
      e_hs = !(hp >= 656 && hp < 752);
      e_de = (hp < 640) && (vp < 480);
      if (d_x !== 10'(h) || d_y !== 10'(v) ||
          d_act !== ((h < 640) && (v < 480)) ||
          d_ls !== (h == 0) || d_fs !== 1'b0 ||
          d_hs !== e_hs || d_vs !== 1'b1 || d_de !== e_de ||
          d_tick !== 1'b0) begin
        mm++;
        if (first < 0) first = n;
      end
      if (d_de === 1'b1) de_cnt++;
      if (d_hs === 1'b0) hs_cnt++;
      if (n == 800) begin
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd1 || d_ls !== 1'b1) begin
          errors++;
          $display("FAIL line_wrap got x%0d y%0d ls%b want x0 y1 ls1",
                   d_x, d_y, d_ls);
        end
      end
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL def_lines bad cycles got %0d want 0 first n=%0d",
               mm, first);
    end
    checks++;
    if (de_cnt !== 1919) begin
      errors++;
      $display("FAIL def_de_count got %0d want 1919", de_cnt);
    end
    checks++;
    if (hs_cnt !== 288) begin
      errors++;
      $display("FAIL def_hs_count got %0d want 288", hs_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    for (int n = 2402; n <= 2700; n++) step();
    checks++;
    if (d_x !== 10'd300 || d_y !== 10'd3) begin
      errors++;
      $display("FAIL pre_reset got x%0d y%0d want x300 y3", d_x, d_y);
    end
    rst_d = 1'b1;
    step();
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0 || d_de !== 1'b0 ||
        {d_hs, d_vs} !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset got x%0d y%0d de%b hv%b want 0 0 0 11",
               d_x, d_y, d_de, {d_hs, d_vs});
    end
    rst_d = 1'b0;
    step();
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0 || d_fs !== 1'b1) begin
      errors++;
      $display("FAIL restart got x%0d y%0d fs%b want 0 0 1",
               d_x, d_y, d_fs);
    end
  endtask

  task automatic test_tick_div3();
    int mm = 0;
    int first = -1;
    int ticks = 0;
    int fss = 0;
    int de_cnt = 0;
    int vs_cnt = 0;
    rst_s = 1'b1;
    repeat (2) step();
    rst_s = 1'b0;
    for (int n = 0; n < 7 * SF; n++) begin
      int h, v, f, hp, vp;
      logic e_hs, e_vs, e_de, e_tick;
      step();
      h = n % SH;
      v = (n / SH) % SV;
      f = n / SF;
      hp = (n - 2) % SH;
      vp = ((n - 2) / SH) % SV;
      e_hs = (n < 2) ? 1'b1 : !(hp >= 10 && hp < 13);
      e_vs = (n < 2) ? 1'b1 : !(vp >= 7 && vp < 9);
      e_de = (n < 2) ? 1'b0 : (hp < 8 && vp < 6);
      e_tick = (h == 0) && (v == 6) && (f % 3 == 2);
      if (s_x !== 5'(h) || s_y !== 5'(v) ||
          s_fs !== (h == 0 && v == 0) || s_hs !== e_hs ||
          s_vs !== e_vs || s_de !== e_de || s_tick !== e_tick) begin
        mm++;
        if (first < 0) first = n;
      end
      if (s_tick === 1'b1) ticks++;
      if (s_fs === 1'b1) fss++;
      if (s_de === 1'b1) de_cnt++;
      if (s_vs === 1'b0) vs_cnt++;
      if (n == 95 || n == 159) begin
        checks++;
        if (s_x !== 5'd15 || s_y !== 5'(v)) begin
          errors++;
          $display("FAIL end_of_line n=%0d got x%0d y%0d want x15 y%0d",
                   n, s_x, s_y, v);
        end
      end
      if (n == 96 || n == 160) begin
        checks++;
        if (s_x !== 5'd0 || s_y !== 5'(v) || s_fs !== (n == 160)) begin
          errors++;
          $display("FAIL wrap n=%0d got x%0d y%0d fs%b want x0 y%0d",
                   n, s_x, s_y, s_fs, v);
        end
      end
      if (n == 416 || n == 896) begin
        checks++;
        if (s_tick !== 1'b1 || s_y !== 5'd6 || s_x !== 5'd0) begin
          errors++;
          $display("FAIL tick_at n=%0d got tick%b x%0d y%0d want 1 0 6",
                   n, s_tick, s_x, s_y);
        end
      end
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL div3_model bad cycles got %0d want 0 first n=%0d",
               mm, first);
    end
    checks++;
    if (ticks !== 2) begin
      errors++;
      $display("FAIL div3_ticks got %0d want 2", ticks);
    end
    checks++;
    if (fss !== 7) begin
      errors++;
      $display("FAIL frame_starts got %0d want 7", fss);
    end
    checks++;
    if (de_cnt !== 336) begin
      errors++;
      $display("FAIL small_de_count got %0d want 336", de_cnt);
    end
    checks++;
    if (vs_cnt !== 224) begin
      errors++;
      $display("FAIL small_vs_count got %0d want 224", vs_cnt);
    end
  endtask

  task automatic test_pause();
    int mm = 0;
    int first = -1;
    int ticks = 0;
    rst_p = 1'b1;
    repeat (2) step();
    rst_p = 1'b0;
    for (int n = 0; n < 5 * SF; n++) begin
      int h, v, f, hp, vp;
      logic e_hs, e_de, e_tick;
      pause_p = ((n / SF) == 1);
      step();
      h = n % SH;
      v = (n / SH) % SV;
      f = n / SF;
      hp = (n - 2) % SH;
      vp = ((n - 2) / SH) % SV;
      e_hs = (n < 2) ? 1'b1 : !(hp >= 10 && hp < 13);
      e_de = (n < 2) ? 1'b0 : (hp < 8 && vp < 6);
      e_tick = (h == 0) && (v == 6) && (f == 2 || f == 4);
      if (p_x !== 5'(h) || p_y !== 5'(v) || p_hs !== e_hs ||
          p_de !== e_de || p_tick !== e_tick) begin
        mm++;
        if (first < 0) first = n;
      end
      if (p_tick === 1'b1) ticks++;
      if (n == SF + 96) begin
        checks++;
        if (p_tick !== 1'b0) begin
          errors++;
          $display("FAIL paused_tick got %b want 0", p_tick);
        end
      end
    end
    pause_p = 1'b0;
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL pause_model bad cycles got %0d want 0 first n=%0d",
               mm, first);
    end
    checks++;
    if (ticks !== 2) begin
      errors++;
      $display("FAIL pause_ticks got %0d want 2", ticks);
    end
  endtask

  task automatic test_nopipe_pol();
    int mm = 0;
    int first = -1;
    int hs_hi = 0;
    rst_z = 1'b1;
    repeat (2) step();
    checks++;
    if ({z_hs, z_vs, z_de} !== 3'b010) begin
      errors++;
      $display("FAIL z_rst got hs/vs/de %b want 010", {z_hs, z_vs, z_de});
    end
    rst_z = 1'b0;
    for (int n = 0; n <= 53; n++) begin
      int h, v;
      step();
      h = n % SH;
      v = n / SH;
      if (z_x !== 5'(h) || z_y !== 5'(v) ||
          z_hs !== (h >= 10 && h < 13) || z_vs !== 1'b1 ||
          z_de !== (h < 8 && v < 6) || z_de !== z_act) begin
        mm++;
        if (first < 0) first = n;
      end
      if (z_hs === 1'b1) hs_hi++;
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL z_model bad cycles got %0d want 0 first n=%0d",
               mm, first);
    end
    checks++;
    if (hs_hi !== 9) begin
      errors++;
      $display("FAIL z_hs_high got %0d want 9", hs_hi);
    end
    checks++;
    if (z_x !== 5'd5 || z_y !== 5'd3) begin
      errors++;
      $display("FAIL z_pre_reset got x%0d y%0d want x5 y3", z_x, z_y);
    end
    rst_z = 1'b1;
    step();
    checks++;
    if (z_x !== 5'd0 || z_y !== 5'd0 || {z_hs, z_vs, z_de} !== 3'b010) begin
      errors++;
      $display("FAIL z_mid_reset got x%0d y%0d hs/vs/de %b want 0 0 010",
               z_x, z_y, {z_hs, z_vs, z_de});
    end
    rst_z = 1'b0;
    step();
    checks++;
    if (z_x !== 5'd0 || z_fs !== 1'b1 || z_de !== 1'b1 || z_hs !== 1'b0) begin
      errors++;
      $display("FAIL z_cycle0 got x%0d fs%b de%b hs%b want 0 1 1 0",
               z_x, z_fs, z_de, z_hs);
    end
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    rst_p = 1'b1;
    rst_z = 1'b1;
    pause_d = 1'b0;
    pause_s = 1'b0;
    pause_p = 1'b0;
    pause_z = 1'b0;
    test_reset();
    test_default_lines();
    test_midframe_reset();
    test_tick_div3();
    test_pause();
    test_nopipe_pol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
